// File: rtl/glcm_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between the GLCM input-matrix
// fetcher (req0) and the GLCM-table fetcher (req1); one burst in flight at a time.
module glcm_axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [3:0]            req0_len,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_last,
    input  logic                  rsp0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [3:0]            req1_len,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_last,
    input  logic                  rsp1_ready,
    output logic [ID_WIDTH-1:0]   arid_m_inf,
    output logic [ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [3:0]            arlen_m_inf,
    output logic [2:0]            arsize_m_inf,
    output logic [1:0]            arburst_m_inf,
    output logic                  arvalid_m_inf,
    input  logic                  arready_m_inf,
    input  logic [ID_WIDTH-1:0]   rid_m_inf,
    input  logic [DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [1:0]            rresp_m_inf,
    input  logic                  rlast_m_inf,
    input  logic                  rvalid_m_inf,
    output logic                  rready_m_inf,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t                state, state_nxt;
    logic                  rr_ptr;
    logic                  owner;
    logic                  any_req;
    logic                  grant_side;
    logic                  beat;
    logic                  beat_err;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [3:0]            lat_len;
    logic [3:0]            beat_cnt;
    logic [ID_WIDTH-1:0]   owner_id;

    // rr_ptr only breaks ties; a lone requester is always served.
    assign any_req    = req0_valid | req1_valid;
    assign grant_side = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    assign owner_id   = {{(ID_WIDTH-1){1'b0}}, owner};
    assign beat       = (state == DATA) & rvalid_m_inf & rready_m_inf;

    // A beat is bad if its response, id or last-marking disagrees with the granted burst.
    assign beat_err = (rresp_m_inf != 2'b00) ||
                      (rid_m_inf != owner_id) ||
                      (rlast_m_inf && (beat_cnt != lat_len)) ||
                      (!rlast_m_inf && (beat_cnt == lat_len));

    assign arid_m_inf    = owner_id;
    assign araddr_m_inf  = lat_addr;
    assign arlen_m_inf   = lat_len;
    assign arsize_m_inf  = 3'b010;
    assign arburst_m_inf = 2'b01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ADDR;
            ADDR:    if (arready_m_inf) state_nxt = DATA;
            DATA:    if (beat && rlast_m_inf) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst context is captured at grant so the AR fields stay stable until handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
            lat_addr <= '0;
            lat_len  <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if ((state == IDLE) && any_req) begin
                owner    <= grant_side;
                lat_addr <= grant_side ? req1_addr : req0_addr;
                lat_len  <= grant_side ? req1_len : req0_len;
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 4'd1;
                if (rlast_m_inf) rr_ptr <= ~owner;
                if (beat_err) err <= 1'b1;
            end
        end
    end

    always_comb begin
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        arvalid_m_inf = 1'b0;
        rready_m_inf  = 1'b0;
        rsp0_valid    = 1'b0;
        rsp0_data     = '0;
        rsp0_last     = 1'b0;
        rsp1_valid    = 1'b0;
        rsp1_data     = '0;
        rsp1_last     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = any_req & ~grant_side;
                req1_ready = any_req & grant_side;
            end
            ADDR: arvalid_m_inf = 1'b1;
            DATA: begin
                rready_m_inf = owner ? rsp1_ready : rsp0_ready;
                if (owner) begin
                    rsp1_valid = rvalid_m_inf;
                    rsp1_data  = rdata_m_inf;
                    rsp1_last  = rlast_m_inf;
                end else begin
                    rsp0_valid = rvalid_m_inf;
                    rsp0_data  = rdata_m_inf;
                    rsp0_last  = rlast_m_inf;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_glcm_axi_rd_arbiter.sv
// Scoreboard bench for glcm_axi_rd_arbiter: the bench plays both requesters and
// the AXI slave, queuing the expected AR and R traffic at grant time.
module tb_glcm_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic [3:0]  req0_len, req1_len;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_last, rsp1_last;
    logic        rsp0_ready, rsp1_ready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        err;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [3:0]  id;
    } ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    ar_t   ar_q[$];
    beat_t beat_q[$];
    int    total_cnt = 0;
    int    pass_cnt  = 0;

    glcm_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_last(rsp0_last), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_last(rsp1_last), .rsp1_ready(rsp1_ready),
        .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen), .arsize_m_inf(arsize),
        .arburst_m_inf(arburst), .arvalid_m_inf(arvalid), .arready_m_inf(arready),
        .rid_m_inf(rid), .rdata_m_inf(rdata), .rresp_m_inf(rresp), .rlast_m_inf(rlast),
        .rvalid_m_inf(rvalid), .rready_m_inf(rready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    endtask

    function automatic logic [31:0] beat_data(input int side, input logic [31:0] addr, input int i);
        logic [7:0] idx;
        idx = 8'(i);
        return {(side == 1) ? 8'hB1 : 8'hA0, addr[15:0], idx};
    endfunction

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [3:0] l0,
                                 input logic v1, input logic [31:0] a1, input logic [3:0] l1);
        req0_valid = v0; req0_addr = a0; req0_len = l0;
        req1_valid = v1; req1_addr = a1; req1_len = l1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req0_ready", req0_ready, 0);
        checkOutput("rst_req1_ready", req1_ready, 0);
        checkOutput("rst_rsp0_valid", rsp0_valid, 0);
        checkOutput("rst_rsp1_valid", rsp1_valid, 0);
        checkOutput("rst_rsp0_last", rsp0_last, 0);
        checkOutput("rst_rsp1_last", rsp1_last, 0);
        checkOutput("rst_rsp0_data", rsp0_data, 0);
        checkOutput("rst_rsp1_data", rsp1_data, 0);
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_arid", arid, 0);
        checkOutput("rst_araddr", araddr, 0);
        checkOutput("rst_arlen", arlen, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_arsize", arsize, 3'b010);
        checkOutput("rst_arburst", arburst, 2'b01);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 32'h0, 4'h0, 0, 32'h0, 4'h0);
        rsp0_ready = 0; rsp1_ready = 0; arready = 0;
        rvalid = 0; rlast = 0; rresp = 0; rid = 0; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        checkResetOutputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left just after a falling edge; grants, plays AR and R for one burst.
    task automatic serve(input int side, input int ar_wait, input bit toggle, input int bad_beat,
                         input int n_beats, input bit drop_req, input int abort_beat);
        ar_t         exp_ar;
        beat_t       exp_b;
        logic [31:0] addr;
        logic [3:0]  len;
        logic        want_ready;
        int          b, cyc;
        bit          granted;
        addr = (side == 1) ? req1_addr : req0_addr;
        len  = (side == 1) ? req1_len : req0_len;
        granted = 0;
        for (int k = 0; k < 20 && !granted; k++) begin
            #1;
            if (req0_ready || req1_ready) granted = 1;
            else @(negedge clk);
        end
        checkOutput("grant", {req1_ready, req0_ready}, (side == 1) ? 2'b10 : 2'b01);
        if (!granted) return;
        ar_q.push_back('{addr: addr, len: len, id: 4'(side)});
        for (int i = 0; i < n_beats; i++)
            beat_q.push_back('{data: beat_data(side, addr, i), last: (i == n_beats - 1)});
        @(negedge clk);
        if (drop_req) begin
            req0_valid = 0;
            req1_valid = 0;
        end
        exp_ar = ar_q.pop_front();
        for (int w = 0; w <= ar_wait; w++) begin
            arready = (w == ar_wait);
            #1;
            checkOutput("arvalid", arvalid, 1);
            checkOutput("araddr", araddr, exp_ar.addr);
            checkOutput("arlen", arlen, exp_ar.len);
            if (w == ar_wait) begin
                checkOutput("arid", arid, exp_ar.id);
                checkOutput("arsize", arsize, 3'b010);
                checkOutput("arburst", arburst, 2'b01);
            end
            @(negedge clk);
        end
        arready = 0;
        #1;
        checkOutput("arvalid_drop", arvalid, 0);
        b = 0;
        cyc = 0;
        while (b < n_beats && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            rvalid = 1;
            rid    = 4'(side);
            rdata  = beat_data(side, addr, b);
            rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (b == n_beats - 1);
            want_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            rsp1_ready = (side == 1) ? want_ready : !want_ready;
            rsp0_ready = (side == 1) ? !want_ready : want_ready;
            if (b == abort_beat) begin
                rst = 1'b1;
                #1;
                checkResetOutputs();
                @(negedge clk);
                rst = 1'b0;
                rvalid = 0; rlast = 0; rresp = 0; rsp0_ready = 0; rsp1_ready = 0;
                beat_q.delete();
                return;
            end
            #1;
            checkOutput("rready", rready, want_ready);
            checkOutput("rsp_other_valid", (side == 1) ? rsp0_valid : rsp1_valid, 0);
            if (want_ready) begin
                exp_b = beat_q.pop_front();
                checkOutput("rsp_valid", (side == 1) ? rsp1_valid : rsp0_valid, 1);
                checkOutput("rsp_data", (side == 1) ? rsp1_data : rsp0_data, exp_b.data);
                checkOutput("rsp_last", (side == 1) ? rsp1_last : rsp0_last, exp_b.last);
                b++;
            end
            cyc++;
        end
        checkOutput("beats_delivered", b, n_beats);
        @(negedge clk);
        rvalid = 0; rlast = 0; rresp = 0; rsp0_ready = 0; rsp1_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        doReset();

        // Single requester, full 16-beat burst
        applyStimulus(1, 32'h0000_1000, 4'd15, 0, 32'h0, 4'd0);
        serve(0, 0, 0, -1, 16, 1, -1);
        #1 checkOutput("t1_err", err, 0);

        // Both requesters from reset: req0 first, then strict alternation
        doReset();
        applyStimulus(1, 32'h0000_2000, 4'd1, 1, 32'h0000_3000, 4'd2);
        serve(0, 0, 0, -1, 2, 0, -1);
        serve(1, 0, 0, -1, 3, 0, -1);
        serve(0, 0, 0, -1, 2, 0, -1);
        serve(1, 0, 0, -1, 3, 1, -1);
        #1 checkOutput("t2_err", err, 0);

        // AR stalled five cycles
        applyStimulus(1, 32'h0000_4440, 4'd2, 0, 32'h0, 4'd0);
        serve(0, 5, 0, -1, 3, 1, -1);

        // Requester 1 back-pressure toggling
        applyStimulus(0, 32'h0, 4'd0, 1, 32'h0000_5500, 4'd3);
        serve(1, 0, 1, -1, 4, 1, -1);
        #1 checkOutput("t4_err", err, 0);

        // Error response on beat 2 is sticky
        applyStimulus(1, 32'h0000_6000, 4'd3, 0, 32'h0, 4'd0);
        serve(0, 0, 0, 1, 4, 1, -1);
        #1 checkOutput("t5_err_resp", err, 1);
        repeat (3) @(negedge clk);
        #1 checkOutput("t5_err_hold", err, 1);
        doReset();

        // Early rlast on beat 3 of an 8-beat burst, then a single-beat burst proves IDLE
        applyStimulus(0, 32'h0, 4'd0, 1, 32'h0000_7000, 4'd7);
        serve(1, 0, 0, -1, 3, 1, -1);
        #1 checkOutput("t5_err_early_last", err, 1);
        applyStimulus(1, 32'h0000_8000, 4'd0, 0, 32'h0, 4'd0);
        serve(0, 0, 0, -1, 1, 1, -1);
        #1 checkOutput("t5_err_sticky", err, 1);

        // Reset during beat 5 of 16, then a fresh req1 burst
        doReset();
        applyStimulus(0, 32'h0, 4'd0, 1, 32'h0000_9000, 4'd15);
        serve(1, 0, 0, -1, 16, 1, 4);
        applyStimulus(0, 32'h0, 4'd0, 1, 32'h0000_A000, 4'd2);
        serve(1, 1, 0, -1, 3, 1, -1);
        #1 checkOutput("t6_err", err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
